// File: rtl/my_multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encoding,
// iteration count and small two's-complement helpers.
package my_multdiv_pkg;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = 6;

  // Counter value seen during the final iteration (edge 32 sees 31).
  localparam logic [CNT_W-1:0] LAST_ITER = 6'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Magnitude of a signed word; 0x80000000 maps to 2^31 read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/my_multdiv_counter.sv
// 6-bit iteration counter with synchronous clear; done flags 32 iterations.
module multdiv_counter
  import my_multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_r;

  // Count iterations; a clear (new start) takes priority over counting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= 6'd0;
    end else if (clear) begin
      count_r <= 6'd0;
    end else if (enable) begin
      count_r <= count_r + 6'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign done  = (count_r == 6'(ITERATIONS));

endmodule

// File: rtl/two_level_carry_lookahead.sv
// Two-level carry-lookahead adder: 4-bit groups with bit-level lookahead
// inside each group and group generate/propagate at the second level.
// WIDTH must be a multiple of 4.
module two_level_carry_lookahead #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] c_s;
  logic [NG-1:0]    gg_s;
  logic [NG-1:0]    gp_s;
  logic [NG:0]      gc_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // First level: group generate and propagate from the bit terms
  always_comb begin
    gg_s = {NG{1'b0}};
    gp_s = {NG{1'b0}};
    for (int k = 0; k < NG; k++) begin
      gp_s[k] = &p_s[4*k +: 4];
      gg_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
    end
  end

  // Second level: carry into each group from group terms
  always_comb begin
    gc_s = {(NG+1){1'b0}};
    gc_s[0] = cin;
    for (int k = 0; k < NG; k++) begin
      gc_s[k+1] = gg_s[k] | (gp_s[k] & gc_s[k]);
    end
  end

  // Bit carries inside each group from the group carry-in
  always_comb begin
    c_s = {WIDTH{1'b0}};
    for (int k = 0; k < NG; k++) begin
      c_s[4*k]   = gc_s[k];
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
    end
  end

  assign sum  = p_s ^ c_s;
  assign cout = gc_s[NG];

endmodule

// File: rtl/my_multdiv.sv
// Iterative signed multiply (shift-add on magnitudes) and restoring divide,
// one iteration per clock, 32 iterations, single-cycle result-ready pulse.
module my_multdiv
  import my_multdiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  state_t state_r;
  state_t state_nxt_s;

  logic             start_s;
  logic             busy_s;
  logic             last_iter_s;
  logic [CNT_W-1:0] count_s;
  logic             done_s;

  // hi: product high half / partial remainder; lo: multiplier / quotient
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] addend_r;
  logic        neg_r;
  logic        div_zero_r;
  logic        div_ovf_r;

  logic [31:0] add_a_s;
  logic [31:0] add_b_s;
  logic        add_cin_s;
  logic [31:0] add_sum_s;
  logic        add_cout_s;
  logic        sub_ok_s;
  logic [31:0] hi_step_s;
  logic [31:0] lo_step_s;

  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] res_nxt_s;
  logic        exc_nxt_s;
  logic        rdy_nxt_s;

  assign start_s     = ctrl_MULT | ctrl_DIV;
  assign busy_s      = (state_r == ST_MUL) || (state_r == ST_DIV);
  assign last_iter_s = busy_s && (count_s == LAST_ITER);

  multdiv_counter u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start_s),
    .enable  (busy_s & ~done_s),
    .count   (count_s),
    .done    (done_s)
  );

  two_level_carry_lookahead #(.WIDTH(32)) u_adder (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: any start restarts; ctrl_MULT wins when both are high
  always_comb begin
    state_nxt_s = ST_IDLE;
    if (ctrl_MULT) begin
      state_nxt_s = ST_MUL;
    end else if (ctrl_DIV) begin
      state_nxt_s = ST_DIV;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_MUL:  state_nxt_s = last_iter_s ? ST_DONE : ST_MUL;
        ST_DIV:  state_nxt_s = last_iter_s ? ST_DONE : ST_DIV;
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Adder operands: trial subtract of the divisor, or conditional add of the multiplicand
  always_comb begin
    add_a_s   = 32'd0;
    add_b_s   = 32'd0;
    add_cin_s = 1'b0;
    if (state_r == ST_DIV) begin
      add_a_s   = {hi_r[30:0], lo_r[31]};
      add_b_s   = ~addend_r;
      add_cin_s = 1'b1;
    end else begin
      add_a_s   = hi_r;
      add_b_s   = lo_r[0] ? addend_r : 32'd0;
      add_cin_s = 1'b0;
    end
  end

  // One iteration: restore-or-keep for divide, add-then-shift-right for multiply
  always_comb begin
    sub_ok_s  = 1'b0;
    hi_step_s = hi_r;
    lo_step_s = lo_r;
    if (state_r == ST_DIV) begin
      // The shifted remainder's bit 32 (hi_r[31]) set means it exceeds any divisor
      sub_ok_s  = hi_r[31] | add_cout_s;
      hi_step_s = sub_ok_s ? add_sum_s : {hi_r[30:0], lo_r[31]};
      lo_step_s = {lo_r[30:0], sub_ok_s};
    end else begin
      sub_ok_s  = 1'b0;
      hi_step_s = {add_cout_s, add_sum_s[31:1]};
      lo_step_s = {add_sum_s[0], lo_r[31:1]};
    end
  end

  // Operand capture on a start, then one iteration per cycle while busy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      addend_r   <= 32'd0;
      neg_r      <= 1'b0;
      div_zero_r <= 1'b0;
      div_ovf_r  <= 1'b0;
    end else if (start_s) begin
      hi_r       <= 32'd0;
      neg_r      <= data_operandA[31] ^ data_operandB[31];
      div_zero_r <= (data_operandB == 32'd0);
      div_ovf_r  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      if (ctrl_MULT) begin
        addend_r <= abs32(data_operandA);
        lo_r     <= abs32(data_operandB);
      end else begin
        addend_r <= abs32(data_operandB);
        lo_r     <= abs32(data_operandA);
      end
    end else if (busy_s) begin
      hi_r       <= hi_step_s;
      lo_r       <= lo_step_s;
      addend_r   <= addend_r;
      neg_r      <= neg_r;
      div_zero_r <= div_zero_r;
      div_ovf_r  <= div_ovf_r;
    end else begin
      hi_r       <= hi_r;
      lo_r       <= lo_r;
      addend_r   <= addend_r;
      neg_r      <= neg_r;
      div_zero_r <= div_zero_r;
      div_ovf_r  <= div_ovf_r;
    end
  end

  // FSM outputs: final sign fix-up and flags, loaded as the last iteration completes
  always_comb begin
    prod_s    = neg_r ? neg64({hi_step_s, lo_step_s}) : {hi_step_s, lo_step_s};
    quo_s     = neg_r ? neg32(lo_step_s) : lo_step_s;
    res_nxt_s = data_result;
    exc_nxt_s = data_exception;
    rdy_nxt_s = 1'b0;
    if (state_nxt_s == ST_DONE) begin
      rdy_nxt_s = 1'b1;
      if (state_r == ST_MUL) begin
        res_nxt_s = prod_s[31:0];
        exc_nxt_s = ~((&prod_s[63:31]) | ~(|prod_s[63:31]));
      end else if (div_zero_r) begin
        res_nxt_s = 32'd0;
        exc_nxt_s = 1'b1;
      end else begin
        res_nxt_s = quo_s;
        exc_nxt_s = div_ovf_r;
      end
    end else begin
      rdy_nxt_s = 1'b0;
    end
  end

  // Registered outputs; result and flag hold until the next completion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_result    <= res_nxt_s;
      data_exception <= exc_nxt_s;
      data_resultRDY <= rdy_nxt_s;
    end
  end

endmodule
